// File: rtl/i2s_multi_capture.sv
// Captures NUM_SD stereo I2S lines and streams each frame as 2*NUM_SD samples.
// Latency: valid_o rises one clk_i after the right-slot latch that completes a frame.
// Backpressure: ready_i stalls the stream; a frame completing while streaming is dropped and flagged.
//
// Ports:
//   clk_i, rst_ni             system clock, async active-low reset
//   enable_i                  capture enable (capture restarts at the next ws change)
//   sck_i, ws_i, sd_i         raw I2S inputs, synchronised internally
//   sample_o, chan_o          current sample (MSB-aligned, truncated) and channel = 2*line+slot
//   valid_o, ready_i          stream handshake
//   frame_done_o              one-cycle pulse after the last channel of a frame is accepted
//   overflow_o, clear_i       sticky dropped-frame flag and its clear
//   frame_cnt_o               accepted-frame counter, wraps
module i2s_multi_capture #(
    parameter int NUM_SD    = 2,
    parameter int DATA_BITS = 24,
    parameter int SAMPLE_W  = 16,
    localparam int NCH      = 2 * NUM_SD,
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                sck_i,
    input  logic                ws_i,
    input  logic [NUM_SD-1:0]   sd_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic [CW-1:0]       chan_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                frame_done_o,
    output logic                overflow_o,
    input  logic                clear_i,
    output logic [15:0]         frame_cnt_o
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] BC_FULL  = BCW'(DATA_BITS);
    localparam logic [BCW-1:0] BC_LAST  = BCW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NCH - 1);

    // ---------------- input synchronisers ----------------
    logic              sck_m, sck_s, sck_d;
    logic              ws_m, ws_s;
    logic [NUM_SD-1:0] sd_m, sd_s;
    logic              sck_re;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_m <= 1'b0;
            sck_s <= 1'b0;
            sck_d <= 1'b0;
            ws_m  <= 1'b0;
            ws_s  <= 1'b0;
            sd_m  <= '0;
            sd_s  <= '0;
        end else begin
            sck_m <= sck_i;
            sck_s <= sck_m;
            sck_d <= sck_s;
            ws_m  <= ws_i;
            ws_s  <= ws_m;
            sd_m  <= sd_i;
            sd_s  <= sd_m;
        end
    end

    assign sck_re = sck_s & ~sck_d;

    // ---------------- slot capture ----------------
    logic                 ws_prev;
    logic                 slot;
    logic [BCW-1:0]       bitcnt;
    logic                 left_ok;
    logic                 frame_evt;
    logic [DATA_BITS-1:0] shreg [NUM_SD];
    logic [DATA_BITS-1:0] hold  [NCH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ws_prev   <= 1'b0;
            slot      <= 1'b0;
            bitcnt    <= BC_FULL;
            left_ok   <= 1'b0;
            frame_evt <= 1'b0;
            for (int l = 0; l < NUM_SD; l++) shreg[l] <= '0;
            for (int c = 0; c < NCH; c++)    hold[c]  <= '0;
        end else begin
            frame_evt <= 1'b0;
            if (sck_re) begin
                ws_prev <= ws_s;
                if (ws_s != ws_prev) begin
                    // first edge of a slot carries the previous word's tail: skip it
                    slot   <= ws_s;
                    bitcnt <= '0;
                end else if (bitcnt < BC_FULL) begin
                    bitcnt <= bitcnt + 1'b1;
                    for (int l = 0; l < NUM_SD; l++)
                        shreg[l] <= {shreg[l][DATA_BITS-2:0], sd_s[l]};
                    if (bitcnt == BC_LAST) begin
                        for (int l = 0; l < NUM_SD; l++)
                            hold[2*l + (slot ? 1 : 0)] <= {shreg[l][DATA_BITS-2:0], sd_s[l]};
                        if (!slot) begin
                            left_ok <= 1'b1;
                        end else if (left_ok) begin
                            left_ok   <= 1'b0;
                            frame_evt <= 1'b1;
                        end
                    end
                end
            end
            // disabled: park the bit counter so nothing latches until a fresh ws change
            if (!enable_i) begin
                bitcnt    <= BC_FULL;
                left_ok   <= 1'b0;
                frame_evt <= 1'b0;
            end
        end
    end

    // ---------------- output stream FSM ----------------
    typedef enum logic {IDLE, STREAM} state_t;
    state_t              state, state_nxt;
    logic [CW-1:0]       idx;
    logic [DATA_BITS-1:0] obuf [NCH];
    logic                load, advance, finish, ovf_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        ovf_set   = 1'b0;
        valid_o   = 1'b0;
        chan_o    = '0;
        sample_o  = '0;
        case (state)
            IDLE: begin
                if (frame_evt) begin
                    load      = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                valid_o  = 1'b1;
                chan_o   = idx;
                sample_o = obuf[idx][DATA_BITS-1 -: SAMPLE_W];
                // the buffer is busy until the last beat has left, so a new frame is lost
                ovf_set  = frame_evt;
                if (ready_i) begin
                    if (idx == LAST_IDX) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx          <= '0;
            frame_cnt_o  <= '0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
            for (int c = 0; c < NCH; c++) obuf[c] <= '0;
        end else begin
            frame_done_o <= finish;
            if (load) begin
                idx         <= '0;
                frame_cnt_o <= frame_cnt_o + 16'd1;
                for (int c = 0; c < NCH; c++) obuf[c] <= hold[c];
            end else if (advance) begin
                idx <= idx + 1'b1;
            end
            if (ovf_set)      overflow_o <= 1'b1;
            else if (clear_i) overflow_o <= 1'b0;
        end
    end

endmodule
